// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with carry/borrow-in and signed overflow flag.
// Each stage resolves one CW-bit chunk. A single enable stalls every stage at once.
module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_inv;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_inv    = sub ? ~b : b;

    // acc_p shifts right by one chunk per stage: finished sum chunks enter at the
    // top while the remaining chunks of A drain out of the bottom into the adder.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_p;
        logic             sub_p;
        logic             cy_p;
        logic             a_msb_p;
        logic             b_msb_p;
        logic [WIDTH-1:0] acc_p;

        logic             src_vld;
        logic             src_sub;
        logic             src_cy;
        logic             src_a_msb;
        logic             src_b_msb;
        logic [WIDTH-1:0] src_acc;
        logic [CW-1:0]    src_b_chunk;
        logic [CW:0]      chunk_sum;
        logic [WIDTH-1:0] acc_next;

        if (k == 0) begin : g_src
            assign src_vld     = in_valid;
            assign src_sub     = sub;
            assign src_cy      = sub ? ~cin : cin;
            assign src_a_msb   = a[WIDTH-1];
            assign src_b_msb   = b_inv[WIDTH-1];
            assign src_acc     = a;
            assign src_b_chunk = b_inv[CW-1:0];
        end else begin : g_src
            assign src_vld     = g_stage[k-1].vld_p;
            assign src_sub     = g_stage[k-1].sub_p;
            assign src_cy      = g_stage[k-1].cy_p;
            assign src_a_msb   = g_stage[k-1].a_msb_p;
            assign src_b_msb   = g_stage[k-1].b_msb_p;
            assign src_acc     = g_stage[k-1].acc_p;
            assign src_b_chunk = g_stage[k-1].g_rest.b_rest_p[CW-1:0];
        end

        assign chunk_sum = {1'b0, src_acc[CW-1:0]} + {1'b0, src_b_chunk} + (CW+1)'(src_cy);

        if (CW == WIDTH) begin : g_next
            assign acc_next = chunk_sum[CW-1:0];
        end else begin : g_next
            assign acc_next = {chunk_sum[CW-1:0], src_acc[WIDTH-1:CW]};
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p   <= 1'b0;
                sub_p   <= 1'b0;
                cy_p    <= 1'b0;
                a_msb_p <= 1'b0;
                b_msb_p <= 1'b0;
                acc_p   <= '0;
            end else if (en) begin
                vld_p <= src_vld;
                if (src_vld) begin
                    sub_p   <= src_sub;
                    cy_p    <= chunk_sum[CW];
                    a_msb_p <= src_a_msb;
                    b_msb_p <= src_b_msb;
                    acc_p   <= acc_next;
                end
            end
        end

        // Chunks of B' not yet consumed; the store narrows by one chunk per stage.
        if (k < STAGES - 1) begin : g_rest
            localparam int RW = (STAGES - 1 - k) * CW;
            logic [RW-1:0] b_rest_p;
            logic [RW-1:0] src_rest;

            if (k == 0) begin : g_rsrc
                assign src_rest = b_inv[WIDTH-1:CW];
            end else begin : g_rsrc
                assign src_rest = g_stage[k-1].g_rest.b_rest_p[RW+CW-1:CW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_rest_p <= '0;
                end else if (en && src_vld) begin
                    b_rest_p <= src_rest;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_p;
    assign result    = {g_stage[STAGES-1].sub_p ^ g_stage[STAGES-1].cy_p, g_stage[STAGES-1].acc_p};
    assign ovf       = signed_ovf(g_stage[STAGES-1].a_msb_p, g_stage[STAGES-1].b_msb_p,
                                  g_stage[STAGES-1].acc_p[WIDTH-1]);

endmodule
